sync_fifo_param: RTL
====================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, storage entries; power of two, >=4.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, almost_full threshold in entries (1..DEPTH).
REQ-004 Parameter AE_LEVEL, default 2, almost_empty threshold in entries (0..DEPTH-1).
REQ-005 Parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 write  input  1  push request.
REQ-009 read  input  1  pop request.
REQ-010 data_in  input  WIDTH  push data.
REQ-011 clr_err  input  1  synchronous clear of sticky error flags.
REQ-012 data_out  output  WIDTH  read data.
REQ-013 full / empty  output  1 each  occupancy == DEPTH / occupancy == 0.
REQ-014 almost_full / almost_empty  output  1 each  occupancy >= AF_LEVEL / occupancy <= AE_LEVEL.
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 overflow / underflow  output  1 each  sticky error flags.

Function
REQ-017 All DEPTH entries usable; full asserts at exactly DEPTH stored words (no sacrificed slot).
REQ-018 Read and write pointers $clog2(DEPTH) bits, increment by 1 per accepted op, wrap DEPTH-1 -> 0.
REQ-019 Read accepted when read=1 and empty=0.
REQ-020 Write accepted when write=1 and (full=0 or a read is accepted same cycle).
REQ-021 count: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
REQ-022 full, empty, almost_full, almost_empty derived solely from registered count; no glitch-dependent paths.
REQ-023 Rejected write leaves memory, pointers and count unchanged; rejected read leaves data_out and pointers unchanged.
REQ-024 Read on empty with simultaneous write: read rejected, write accepted, count 0 -> 1.
REQ-025 FWFT=0: accepted read loads oldest word into data_out at that edge (1-cycle latency); data_out holds otherwise.
REQ-026 FWFT=1: whenever empty=0, data_out equals oldest stored word with no read required; accepted read advances it to next word at that edge.
REQ-027 FWFT=1: word written into empty FIFO appears on data_out and empty deasserts after the same edge that writes it.
REQ-028 FWFT=1, empty=1: data_out holds last popped value (0 after reset).
REQ-029 overflow sets on any cycle with write=1 rejected; underflow sets on any cycle with read=1 rejected.
REQ-030 Flags stay set until clr_err=1 at an edge; if set condition and clr_err coincide, flag is set.

Reset
REQ-031 reset=1 immediately (no clock) forces pointers 0, count 0, data_out 0, overflow 0, underflow 0.
REQ-032 During/after reset: empty=1, full=0, almost_empty=1, almost_full=0 (given AF_LEVEL>=1).
REQ-033 Memory array not reset; contents unobservable until rewritten.
REQ-034 Reset asserted mid-burst discards all stored words; first write after deassertion lands at entry 0.

Verification
REQ-035 DEPTH=16, FWFT=0: write 0x01..0x10 -> full=1 after 16th edge, count=16, almost_full from count 14; 17th write -> overflow=1, count stays 16.
REQ-036 Drain same FIFO: 16 reads -> data_out 0x01..0x10 in order each 1 cycle after read edge; 17th read -> underflow=1, data_out stays 0x10.
REQ-037 Full FIFO, write+read same cycle with data_in=0xAA -> count stays 16, overflow stays 0, 0xAA read out last after 15 more reads.
REQ-038 Empty FIFO, FWFT=1: write 0x5C -> after that edge empty=0, data_out=0x5C with no read; read -> empty=1, data_out holds 0x5C.
REQ-039 Push/pop 40 words at varying occupancy -> pointer wrap verified, output order matches scoreboard, count matches model every cycle.
REQ-040 Assert reset asynchronously between edges with count=9 and overflow=1 -> outputs take reset values before next edge; clr_err with concurrent overflow keeps flag at 1.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with configurable depth, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a registered or first-word-fall-through read port.
module sync_fifo_param #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  parameter int unsigned FWFT     = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   write,
  input  logic                   read,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   clr_err,
  output logic [WIDTH-1:0]       data_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] AfC    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AeC    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             rd_acc, wr_acc;

  // Status flags come only from the registered count.
  assign full         = (count_q == DepthC);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AfC);
  assign almost_empty = (count_q <= AeC);

  assign count     = count_q;
  assign data_out  = data_out_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  assign rd_acc     = read && !empty;
  assign wr_acc     = write && (!full || rd_acc);
  assign rd_ptr_nxt = rd_ptr_q + 1'b1;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    overflow_d  = (write && !wr_acc) || (overflow_q && !clr_err);
    underflow_d = (read && !rd_acc) || (underflow_q && !clr_err);

    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_nxt;

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (FWFT == 0) begin
      if (rd_acc) data_out_d = mem[rd_ptr_q];
    end else begin
      // Present the word that will be oldest after this edge; when the FIFO
      // holds one word and is popped, only a same-cycle write can replace it.
      if (rd_acc) begin
        if (count_q > CW'(1)) begin
          data_out_d = mem[rd_ptr_nxt];
        end else if (wr_acc) begin
          data_out_d = data_in;
        end
      end else if (wr_acc && empty) begin
        data_out_d = data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule
